// File: rtl/cp0_pkg.sv
// Shared definitions for the CP0 exception sequencer: register indices,
// exception codes, Status/Cause bit positions, handler vectors and FSM states.
package cp0_pkg;

    localparam logic [4:0]  CP0_REG_STATUS   = 5'd12;
    localparam logic [4:0]  CP0_REG_CAUSE    = 5'd13;
    localparam logic [4:0]  CP0_REG_EPC      = 5'd14;

    localparam logic [4:0]  EXC_CODE_TRAP    = 5'b01101;
    localparam logic [4:0]  EXC_CODE_INT     = 5'b00000;

    localparam int          STATUS_IE_BIT    = 0;
    localparam int          STATUS_EXL_BIT   = 1;
    localparam int          STATUS_IM_LSB    = 8;
    localparam int          CAUSE_EXC_LSB    = 2;
    localparam int          CAUSE_IP_LSB     = 8;
    localparam int          CAUSE_IV_BIT     = 23;

    localparam logic [31:0] STATUS_EXL_MASK  = 32'h0000_0002;

    localparam logic [31:0] VEC_BASE0        = 32'h0000_0180;
    localparam logic [31:0] VEC_BASE1        = 32'h0000_0200;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_SAVE_EPC,
        ST_SAVE_CAUSE,
        ST_SET_EXL,
        ST_VECTOR,
        ST_HANDLER,
        ST_RESTORE
    } state_e;

    // Assemble a Cause word from the vector select, pending set and exception code.
    function automatic logic [31:0] makeCause(input logic iv, input logic [7:0] pend,
                                              input logic [4:0] code);
        logic [31:0] word;
        word = '0;
        word[CAUSE_IV_BIT]               = iv;
        word[CAUSE_IP_LSB +: 8]          = pend;
        word[CAUSE_EXC_LSB +: 5]         = code;
        return word;
    endfunction

endpackage

// File: rtl/cp0_prio_enc.sv
// Fixed-priority encoder over the eight pending sources: the lowest set bit wins
// (trap0 > trap1 > irq0 ... irq5). Produces the one-hot winner, its index and a valid flag.
module cp0_prio_enc (
    input  logic [7:0] req_i,
    output logic [7:0] onehot_o,
    output logic [2:0] idx_o,
    output logic       valid_o
);

    // Scan from the highest index down so the lowest set bit is the last one kept.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (req_i[i]) begin
                onehot_o    = '0;
                onehot_o[i] = 1'b1;
                idx_o       = 3'(i);
                valid_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_exc_sequencer.sv
// CP0 exception/interrupt sequencer. Latches trap and irq events into a sticky
// pending set, arbitrates a winner, handshakes with the control unit for an
// instruction boundary, then writes EPC, Cause and Status on consecutive cycles
// and redirects the PC to the handler. eret restores EPC and clears EXL.
// Optional build macro: CP0_IRQ_SYNC_EN adds a 2-flop synchronizer on each irq line.
module cp0_exc_sequencer
    import cp0_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [5:0]  irq_i,
    input  logic [1:0]  trap_i,
    input  logic [31:0] status_i,
    input  logic [31:0] epc_i,
    input  logic        iv_i,
    input  logic [31:0] pcp4_i,
    input  logic        exc_ack_i,
    input  logic        eret_i,
    output logic        exc_req_o,
    output logic        cp0_we_o,
    output logic [4:0]  cp0_addr_o,
    output logic [31:0] cp0_wd_o,
    output logic        pc_load_o,
    output logic [31:0] pc_target_o,
    output logic        exl_o,
    output logic        busy_o
);

    logic [5:0]  irqSync;
    logic [7:0]  events;
    logic [7:0]  pendNow;
    logic [7:0]  qual;
    logic [7:0]  pend_q, pend_d;
    logic [7:0]  winOneHot;
    logic [2:0]  winIdx;
    logic        winValid;

    state_e      state_q;
    logic [7:0]  win_q;
    logic        isTrap_q;
    logic        exc_req_q;
    logic        cp0_we_q;
    logic [4:0]  cp0_addr_q;
    logic [31:0] cp0_wd_q;
    logic        pc_load_q;
    logic [31:0] pc_target_q;
    logic        exl_q;
    logic        busy_q;

`ifdef CP0_IRQ_SYNC_EN
    logic [5:0]  irqMeta_q;
    logic [5:0]  irqSync_q;

    // Two-stage synchronizer for the asynchronous interrupt lines.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irqMeta_q <= '0;
            irqSync_q <= '0;
        end else begin
            irqMeta_q <= irq_i;
            irqSync_q <= irqMeta_q;
        end
    end

    assign irqSync = irqSync_q;
`else
    assign irqSync = irq_i;
`endif

    // Events of this cycle are folded in immediately so a trap is requested the next cycle.
    assign events  = {irqSync, trap_i};
    assign pendNow = pend_q | events;
    assign qual    = pendNow & status_i[STATUS_IM_LSB +: 8];

    cp0_prio_enc u_prio (
        .req_i    (qual),
        .onehot_o (winOneHot),
        .idx_o    (winIdx),
        .valid_o  (winValid)
    );

    // Sticky pending set; only the serviced bit is dropped, at the Cause write.
    always_comb begin
        pend_d = pendNow;
        if (state_q == ST_SAVE_CAUSE) begin
            pend_d = pendNow & ~win_q;
        end
    end

    // Pending register update.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Sequencer FSM; every output is registered for the state it is visible in.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            win_q       <= '0;
            isTrap_q    <= 1'b0;
            exc_req_q   <= 1'b0;
            cp0_we_q    <= 1'b0;
            cp0_addr_q  <= '0;
            cp0_wd_q    <= '0;
            pc_load_q   <= 1'b0;
            pc_target_q <= '0;
            exl_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            cp0_we_q    <= 1'b0;
            cp0_addr_q  <= '0;
            cp0_wd_q    <= '0;
            pc_load_q   <= 1'b0;
            pc_target_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (winValid && status_i[STATUS_IE_BIT]) begin
                        state_q   <= ST_REQ;
                        exc_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (exc_ack_i) begin
                        state_q    <= ST_SAVE_EPC;
                        exc_req_q  <= 1'b0;
                        win_q      <= winOneHot;
                        isTrap_q   <= winValid && (winIdx < 3'd2);
                        cp0_we_q   <= 1'b1;
                        cp0_addr_q <= CP0_REG_EPC;
                        cp0_wd_q   <= pcp4_i;
                    end
                end
                ST_SAVE_EPC: begin
                    state_q    <= ST_SAVE_CAUSE;
                    cp0_we_q   <= 1'b1;
                    cp0_addr_q <= CP0_REG_CAUSE;
                    cp0_wd_q   <= makeCause(iv_i, pendNow & ~win_q,
                                            isTrap_q ? EXC_CODE_TRAP : EXC_CODE_INT);
                end
                ST_SAVE_CAUSE: begin
                    state_q    <= ST_SET_EXL;
                    cp0_we_q   <= 1'b1;
                    cp0_addr_q <= CP0_REG_STATUS;
                    cp0_wd_q   <= status_i | STATUS_EXL_MASK;
                end
                ST_SET_EXL: begin
                    state_q     <= ST_VECTOR;
                    pc_load_q   <= 1'b1;
                    pc_target_q <= iv_i ? VEC_BASE1 : VEC_BASE0;
                end
                ST_VECTOR: begin
                    state_q <= ST_HANDLER;
                    exl_q   <= 1'b1;
                end
                ST_HANDLER: begin
                    if (eret_i) begin
                        state_q     <= ST_RESTORE;
                        exl_q       <= 1'b0;
                        cp0_we_q    <= 1'b1;
                        cp0_addr_q  <= CP0_REG_STATUS;
                        cp0_wd_q    <= status_i & ~STATUS_EXL_MASK;
                        pc_load_q   <= 1'b1;
                        pc_target_q <= epc_i;
                    end
                end
                ST_RESTORE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    exc_req_q <= 1'b0;
                    exl_q     <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign exc_req_o   = exc_req_q;
    assign cp0_we_o    = cp0_we_q;
    assign cp0_addr_o  = cp0_addr_q;
    assign cp0_wd_o    = cp0_wd_q;
    assign pc_load_o   = pc_load_q;
    assign pc_target_o = pc_target_q;
    assign exl_o       = exl_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_cp0_exc_sequencer.sv
// Self-checking bench for cp0_exc_sequencer: directed scenarios followed by
// randomized single-event services, compared against a pending-set model.
module tb_cp0_exc_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [5:0]  irq_i;
    logic [1:0]  trap_i;
    logic [31:0] status_i;
    logic [31:0] epc_i;
    logic        iv_i;
    logic [31:0] pcp4_i;
    logic        exc_ack_i;
    logic        eret_i;
    logic        exc_req_o;
    logic        cp0_we_o;
    logic [4:0]  cp0_addr_o;
    logic [31:0] cp0_wd_o;
    logic        pc_load_o;
    logic [31:0] pc_target_o;
    logic        exl_o;
    logic        busy_o;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  modelPend;

    cp0_exc_sequencer dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .irq_i       (irq_i),
        .trap_i      (trap_i),
        .status_i    (status_i),
        .epc_i       (epc_i),
        .iv_i        (iv_i),
        .pcp4_i      (pcp4_i),
        .exc_ack_i   (exc_ack_i),
        .eret_i      (eret_i),
        .exc_req_o   (exc_req_o),
        .cp0_we_o    (cp0_we_o),
        .cp0_addr_o  (cp0_addr_o),
        .cp0_wd_o    (cp0_wd_o),
        .pc_load_o   (pc_load_o),
        .pc_target_o (pc_target_o),
        .exl_o       (exl_o),
        .busy_o      (busy_o)
    );

    // Free-running 10-unit clock.
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] trap, input logic [5:0] irq);
        trap_i = trap;
        irq_i  = irq;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_req"},    32'(exc_req_o),  32'd0);
        checkOutput({tag, "_we"},     32'(cp0_we_o),   32'd0);
        checkOutput({tag, "_addr"},   32'(cp0_addr_o), 32'd0);
        checkOutput({tag, "_wd"},     cp0_wd_o,        32'd0);
        checkOutput({tag, "_pcload"}, 32'(pc_load_o),  32'd0);
        checkOutput({tag, "_target"}, pc_target_o,     32'd0);
        checkOutput({tag, "_exl"},    32'(exl_o),      32'd0);
        checkOutput({tag, "_busy"},   32'(busy_o),     32'd0);
    endtask

    function automatic logic [7:0] lowestSet(input logic [7:0] m);
        for (int i = 0; i < 8; i++) begin
            if (m[i]) return 8'(1) << i;
        end
        return 8'h00;
    endfunction

    // Entered in the first cycle exc_req should be high; walks the whole entry and eret exit.
    task automatic serviceSeq(input string tag, input int ackDelay, input logic [31:0] epcVal);
        logic [7:0]  win;
        logic [7:0]  pendAfter;
        logic [31:0] cause;
        logic [31:0] vec;
        win       = lowestSet(modelPend & status_i[15:8]);
        pendAfter = modelPend & ~win;
        cause     = (32'(iv_i) << 23) | (32'(pendAfter) << 8)
                  | ((win[1:0] != 2'b00) ? (32'd13 << 2) : 32'd0);
        vec       = iv_i ? 32'h0000_0200 : 32'h0000_0180;
        checkOutput({tag, "_req"}, 32'(exc_req_o), 32'd1);
        for (int i = 0; i < ackDelay; i++) begin
            tick();
            checkOutput({tag, "_req_hold"}, 32'(exc_req_o), 32'd1);
            checkOutput({tag, "_we_hold"},  32'(cp0_we_o),  32'd0);
        end
        exc_ack_i = 1'b1;
        tick();
        exc_ack_i = 1'b0;
        checkOutput({tag, "_epc_we"},   32'(cp0_we_o),   32'd1);
        checkOutput({tag, "_epc_addr"}, 32'(cp0_addr_o), 32'd14);
        checkOutput({tag, "_epc_wd"},   cp0_wd_o,        pcp4_i);
        checkOutput({tag, "_req_drop"}, 32'(exc_req_o),  32'd0);
        tick();
        checkOutput({tag, "_cause_addr"}, 32'(cp0_addr_o), 32'd13);
        checkOutput({tag, "_cause_wd"},   cp0_wd_o,        cause);
        tick();
        checkOutput({tag, "_status_addr"}, 32'(cp0_addr_o), 32'd12);
        checkOutput({tag, "_status_wd"},   cp0_wd_o,        status_i | 32'h2);
        tick();
        checkOutput({tag, "_vec_load"},   32'(pc_load_o), 32'd1);
        checkOutput({tag, "_vec_target"}, pc_target_o,    vec);
        checkOutput({tag, "_vec_we"},     32'(cp0_we_o),  32'd0);
        checkOutput({tag, "_vec_wd"},     cp0_wd_o,       32'd0);
        tick();
        checkOutput({tag, "_exl"},      32'(exl_o),     32'd1);
        checkOutput({tag, "_busy"},     32'(busy_o),    32'd1);
        checkOutput({tag, "_load_off"}, 32'(pc_load_o), 32'd0);
        tick();
        epc_i  = epcVal;
        eret_i = 1'b1;
        tick();
        eret_i = 1'b0;
        checkOutput({tag, "_ret_we"},     32'(cp0_we_o),   32'd1);
        checkOutput({tag, "_ret_addr"},   32'(cp0_addr_o), 32'd12);
        checkOutput({tag, "_ret_wd"},     cp0_wd_o,        status_i & ~32'h2);
        checkOutput({tag, "_ret_load"},   32'(pc_load_o),  32'd1);
        checkOutput({tag, "_ret_target"}, pc_target_o,     epcVal);
        checkOutput({tag, "_ret_exl"},    32'(exl_o),      32'd0);
        tick();
        checkOutput({tag, "_idle_busy"}, 32'(busy_o),   32'd0);
        checkOutput({tag, "_idle_we"},   32'(cp0_we_o), 32'd0);
        modelPend = pendAfter;
    endtask

    // Linear sequence of directed scenarios, then randomized services.
    initial begin
        rst_ni    = 1'b0;
        irq_i     = '0;
        trap_i    = '0;
        status_i  = '0;
        epc_i     = '0;
        iv_i      = 1'b0;
        pcp4_i    = '0;
        exc_ack_i = 1'b0;
        eret_i    = 1'b0;
        modelPend = '0;
        #12;
        checkQuiet("reset");
        checkOutput("reset_pend", 32'(dut.pend_q), 32'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        $display("[TB] trap path");
        status_i = 32'h0000_0101;
        pcp4_i   = 32'h0000_0040;
        iv_i     = 1'b0;
        applyStimulus(2'b01, 6'b0);
        tick();
        applyStimulus(2'b00, 6'b0);
        modelPend |= 8'h01;
        serviceSeq("trap0", 0, 32'h0000_0104);

        $display("[TB] eret outside handler");
        eret_i = 1'b1;
        tick();
        eret_i = 1'b0;
        checkOutput("stray_eret_load", 32'(pc_load_o), 32'd0);
        checkOutput("stray_eret_busy", 32'(busy_o),    32'd0);
        checkOutput("stray_eret_we",   32'(cp0_we_o),  32'd0);

        $display("[TB] masked irq");
        status_i = 32'h0000_0001;
        applyStimulus(2'b00, 6'b000100);
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput("masked_req", 32'(exc_req_o), 32'd0);
        end
        checkOutput("masked_pend4", 32'(dut.pend_q[4]), 32'd1);
        applyStimulus(2'b00, 6'b0);
        modelPend |= 8'h10;
        status_i = 32'h0000_1001;
        pcp4_i   = 32'h0000_0888;
        tick();
        serviceSeq("irq2", 1, 32'h0000_0890);

        $display("[TB] trap1 and irq5 together");
        status_i = 32'h0000_FF01;
        iv_i     = 1'b1;
        pcp4_i   = 32'h0000_1000;
        applyStimulus(2'b10, 6'b100000);
        tick();
        applyStimulus(2'b00, 6'b0);
        modelPend |= 8'h82;
        serviceSeq("prio_trap1", 0, 32'h0000_0104);
        tick();
        pcp4_i = 32'h0000_0108;
        serviceSeq("prio_irq5", 2, 32'h0000_0108);

        $display("[TB] ack stall");
        status_i = 32'h0000_0101;
        iv_i     = 1'b0;
        pcp4_i   = 32'h0000_2220;
        applyStimulus(2'b01, 6'b0);
        tick();
        applyStimulus(2'b00, 6'b0);
        modelPend |= 8'h01;
        for (int i = 0; i < 10; i++) begin
            checkOutput("stall_req", 32'(exc_req_o), 32'd1);
            checkOutput("stall_we",  32'(cp0_we_o),  32'd0);
            if (i == 2) status_i[0] = 1'b0;
            if (i == 7) status_i[0] = 1'b1;
            tick();
        end
        serviceSeq("stall", 0, 32'h0000_2224);

        $display("[TB] reset abort");
        pcp4_i = 32'h0000_3330;
        applyStimulus(2'b01, 6'b0);
        tick();
        applyStimulus(2'b00, 6'b0);
        checkOutput("abort_req", 32'(exc_req_o), 32'd1);
        exc_ack_i = 1'b1;
        tick();
        exc_ack_i = 1'b0;
        checkOutput("abort_epc_addr", 32'(cp0_addr_o), 32'd14);
        tick();
        checkOutput("abort_cause_addr", 32'(cp0_addr_o), 32'd13);
        #2;
        rst_ni = 1'b0;
        #1;
        checkQuiet("abort");
        @(posedge clk_i);
        #1;
        rst_ni    = 1'b1;
        modelPend = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("abort_after_we",   32'(cp0_we_o), 32'd0);
            checkOutput("abort_after_busy", 32'(busy_o),   32'd0);
        end

        $display("[TB] randomized services");
        for (int n = 0; n < 16; n++) begin
            int          b;
            int          ackDelay;
            logic [31:0] st;
            b        = int'($urandom_range(0, 7));
            ackDelay = int'($urandom_range(0, 3));
            st       = $urandom;
            st[0]    = 1'b1;
            st[8 + b] = 1'b1;
            status_i = st;
            iv_i     = 1'($urandom_range(0, 1));
            pcp4_i   = $urandom;
            if (b < 2) begin
                applyStimulus(2'(1 << b), 6'b0);
            end else begin
                applyStimulus(2'b00, 6'(1 << (b - 2)));
            end
            tick();
            applyStimulus(2'b00, 6'b0);
            modelPend |= 8'(1 << b);
            serviceSeq("rand", ackDelay, $urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cp0_exc_sequencer.md
# cp0_exc_sequencer

Sequences exception and interrupt entry/exit for the CP0 register file: latches masked trap and interrupt events, arbitrates one winner, and handshakes with the control unit for an instruction boundary. It then drives the CP0 write port (EPC, Cause, Status) over consecutive cycles and redirects the PC to the handler vector. On `eret` it restores EPC into the PC and clears EXL. It sits between the control unit, the PC mux and CP0.

## Interface
- `VEC_BASE0`, 32'h0000_0180, handler address when `iv`=0
- `VEC_BASE1`, 32'h0000_0200, handler address when `iv`=1
- `clk` in 1 system clock, rising edge
- `rst` in 1 asynchronous, active-low reset
- `irq` in 6 external interrupt lines, level, asynchronous to `clk`
- `trap` in 2 ALU trap pulses, 1 cycle each, synchronous
- `status_in` in 32 current CP0 reg 12: [15:8] enable mask, [0] IE
- `epc_in` in 32 current CP0 reg 14
- `iv` in 1 CP0 Cause[23] vector select
- `pcp4` in 32 PC+4 of the instruction at the boundary
- `exc_ack` in 1 CU: boundary reached, pipeline held
- `eret` in 1 CU: return-from-exception decoded, 1-cycle pulse
- `exc_req` out 1 request to CU for a boundary
- `cp0_we` out 1 CP0 write enable
- `cp0_addr` out 5 CP0 register index
- `cp0_wd` out 32 CP0 write data
- `pc_load` out 1 1-cycle PC override strobe
- `pc_target` out 32 PC override value
- `exl` out 1 handler in progress
- `busy` out 1 FSM not in IDLE

## Operation
- Pending register `pend[7:0]`: bit 0/1 = trap[0]/trap[1], bits 2..7 = irq[0..5]. Bits set sticky on event; cleared only at SAVE_CAUSE, for the serviced bit only (irq bits re-set next cycle if the line is still high).
- Qualified set `q = pend & status_in[15:8]`. Service needs `q != 0` and `status_in[0]`=1.
- Priority: lowest bit index wins (trap0 > trap1 > irq0 … irq5).
- Exception code: 5'b01101 for a trap, 5'b00000 for an irq.
- FSM states:
  - IDLE: leave when service condition holds -> REQ.
  - REQ: `exc_req`=1. Hold until `exc_ack` -> SAVE_EPC. Capture winner and `pcp4` on the ack cycle.
  - SAVE_EPC: write reg 14 = captured `pcp4`.
  - SAVE_CAUSE: write reg 13 = {8'b0, iv, 7'b0, pend[7:0] with winner cleared, 1'b0, code, 2'b0}.
  - SET_EXL: write reg 12 = `status_in` with bit 1 set.
  - VECTOR: `pc_load`=1, `pc_target` = `iv` ? VEC_BASE1 : VEC_BASE0.
  - HANDLER: `exl`=1. On `eret` -> RESTORE.
  - RESTORE: write reg 12 = `status_in` with bit 1 cleared; `pc_load`=1, `pc_target` = `epc_in`.
  - After RESTORE -> IDLE.
- Unused writes: when `cp0_we`=0, drive `cp0_addr` and `cp0_wd` to 0.

## Timing
- Reset values: all outputs 0, `pend`=0, state IDLE. Reset mid-sequence aborts without issuing further writes.
- Latency: trap pulse at cycle T -> `exc_req` at T+1. The ack cycle is A; then SAVE_EPC at A+1, SAVE_CAUSE at A+2, SET_EXL at A+3, and `pc_load` at A+4.
- With IRQ_SYNC_EN, irq-to-`pend` latency is 2 extra cycles.
- `exc_req` stays high until acked; dropping `status_in[0]` while in REQ does not withdraw it.
- Events arriving in any state other than IDLE are latched in `pend` and not serviced until return to IDLE; no nesting.
- `eret` outside HANDLER is ignored.
- A trap and an irq arriving on the same cycle are both latched; the trap is serviced first, and the irq is serviced on the next IDLE pass.

## Configuration
- `CP0_IRQ_SYNC_EN` defined: each `irq` bit passes through a 2-flop synchronizer (reset 0) before `pend`.
- `CP0_IRQ_SYNC_EN` undefined: `irq` is sampled directly into `pend`. The source must then be synchronous to `clk`.

## Structure
- Shared package `cp0_pkg`:
  - CP0 register indices (12, 13, 14)
  - exception codes
  - Status/Cause bit positions
  - state enum
- One sub-module, `cp0_prio_enc`: 8-bit fixed-priority encoder producing a one-hot winner, an index, and a valid bit.

## Test plan
- Trap path: `status_in`=32'h0000_0101, `pcp4`=32'h0000_0040, `trap[0]` pulse, `exc_ack` one cycle later.
  - Writes: reg14=32'h40, then reg13 code 5'b01101, then reg12 bit1=1.
  - Then `pc_load` with `pc_target`=32'h180.
- Masked irq: `status_in`=32'h0000_0001, `irq[2]`=1. `exc_req` stays 0 for 20 cycles; `pend[4]`=1.
- Priority: `irq[5]` and `trap[1]` on the same cycle, all enabled, `iv`=1.
  - Cause code 5'b01101 and target 32'h200 first.
  - After `eret`, the irq[5] sequence follows with code 5'b00000.
- Return: in HANDLER, `epc_in`=32'h0000_0104, `eret` pulse.
  - Next cycle: reg12 write with bit1=0, `pc_load` target 32'h104, then `busy`=0.
- Reset abort: assert `rst`=0 during SAVE_CAUSE. All outputs 0 immediately; no further `cp0_we` after release.
- Ack stall: hold `exc_ack`=0 for 10 cycles. `exc_req` stays 1 and no CP0 write occurs until the ack.
